// File: rtl/multdiv_ctrl_pkg.sv
// Shared decode constants, status codes and FSM encoding for the
// iterative multiply/divide sequencer.
package multdiv_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RD_HI  = 26;
  localparam int IR_RD_LO  = 22;
  localparam int IR_ALU_HI = 6;
  localparam int IR_ALU_LO = 2;

  localparam logic [31:0] RS_MUL_OVF = 32'd4;
  localparam logic [31:0] RS_DIV_EXC = 32'd5;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_DONE
  } md_state_e;

  typedef struct packed {
    logic       start;
    logic       is_div;
    logic [4:0] rd;
  } md_dec_t;

  function automatic md_dec_t md_decode(
    input logic [31:0] ir
  );
    md_dec_t    d;
    logic [4:0] opc;
    logic [4:0] alu;
    opc  = ir[IR_OPC_HI:IR_OPC_LO];
    alu  = ir[IR_ALU_HI:IR_ALU_LO];
    d    = '0;
    d.rd = ir[IR_RD_HI:IR_RD_LO];
    unique case (1'b1)
      (opc == OP_RTYPE && alu == ALU_MULT): begin
        d.start = 1'b1;
      end
      (opc == OP_RTYPE && alu == ALU_DIV): begin
        d.start  = 1'b1;
        d.is_div = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] mag(
    input logic [31:0] x
  );
    return x[31] ? -x : x;
  endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// Shared Booth multiply / restoring divide datapath; one step per
// cycle, with the post-step result and exception flag exposed.
module multdiv_iter_core
  import multdiv_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        fast,
  output logic [31:0] res_nxt,
  output logic        exc_nxt
);

  // hi: Booth accumulator or partial remainder (33b to absorb INT_MIN)
  // lo: multiplier / dividend, shifting into product low / quotient
  logic [32:0] hi;
  logic [31:0] lo;
  logic [31:0] m;
  logic        qm1;
  logic        div_q;
  logic        neg_q;
  logic        dz_q;
  logic        dov_q;
  logic        fast_q;

  logic [32:0] m_ext;
  logic [32:0] sum;
  logic [32:0] sh;
  logic [32:0] diff;
  logic [32:0] hi_n;
  logic [31:0] lo_n;
  logic        qm1_n;
  logic [63:0] prod;
  logic [31:0] quo;

  logic ld_dz;
  logic ld_dov;

  assign ld_dz  = is_div && op_b == '0;
  assign ld_dov = is_div && op_a == INT_MIN
               && op_b == '1;

  always_comb begin
    m_ext = {m[31], m};
    unique case ({lo[0], qm1})
      2'b01:   sum = hi + m_ext;
      2'b10:   sum = hi - m_ext;
      default: sum = hi;
    endcase
    sh   = {hi[31:0], lo[31]};
    diff = sh - {1'b0, m};
    if (div_q) begin
      qm1_n = qm1;
      if (!diff[32]) begin
        hi_n = diff;
        lo_n = {lo[30:0], 1'b1};
      end else begin
        hi_n = sh;
        lo_n = {lo[30:0], 1'b0};
      end
    end else begin
      hi_n  = {sum[32], sum[32:1]};
      lo_n  = {sum[0], lo[31:1]};
      qm1_n = lo[0];
    end
  end

  assign prod = {hi_n[31:0], lo_n};
  assign quo  = neg_q ? -lo_n : lo_n;

  // Zero operands and div exceptions have closed-form answers, so the
  // result never depends on how many steps were actually taken.
  always_comb begin
    res_nxt = '0;
    exc_nxt = 1'b0;
    if (fast_q) begin
      res_nxt = dov_q ? INT_MIN : '0;
      exc_nxt = dz_q | dov_q;
    end else if (div_q) begin
      res_nxt = quo;
      exc_nxt = 1'b0;
    end else begin
      res_nxt = prod[31:0];
      exc_nxt = prod[63:32] != {32{prod[31]}};
    end
  end

  assign fast = fast_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      qm1    <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
      dov_q  <= 1'b0;
      fast_q <= 1'b0;
    end else if (load) begin
      hi     <= '0;
      lo     <= is_div ? mag(op_a) : op_b;
      m      <= is_div ? mag(op_b) : op_a;
      qm1    <= 1'b0;
      div_q  <= is_div;
      neg_q  <= op_a[31] ^ op_b[31];
      dz_q   <= ld_dz;
      dov_q  <= ld_dov;
      fast_q <= op_a == '0 || op_b == '0
             || ld_dz || ld_dov;
    end else if (step) begin
      hi  <= hi_n;
      lo  <= lo_n;
      qm1 <= qm1_n;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter and result
// registers. Build option: MULTDIV_EARLY_DONE_EN (short-circuit ops).
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int          ITERS           = 32,
  parameter logic [31:0] RSTATUS_MUL_OVF = RS_MUL_OVF,
  parameter logic [31:0] RSTATUS_DIV_EXC = RS_DIV_EXC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir_in,
  input  logic [31:0] dx_operand_a,
  input  logic [31:0] dx_operand_b,
  output logic        multdiv_is_running,
  output logic        multdiv_result_ready,
  output logic [31:0] multdiv_result,
  output logic [4:0]  multdiv_rd,
  output logic        multdiv_exception,
  output logic [31:0] multdiv_rstatus
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

`ifdef MULTDIV_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  md_state_e     state;
  logic [CW-1:0] count;
  logic [4:0]    rd_q;
  logic          div_q;

  md_dec_t     dec;
  logic        load;
  logic        step;
  logic        finish;
  logic        fast;
  logic [31:0] res_nxt;
  logic        exc_nxt;

  assign dec  = md_decode(dx_ir_in);
  assign step = state == MD_RUN;
  assign load = dec.start && !step;

  assign finish = step
               && (count == LAST || (EARLY && fast));

  multdiv_iter_core u_core (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .is_div  (dec.is_div),
    .op_a    (dx_operand_a),
    .op_b    (dx_operand_b),
    .fast    (fast),
    .res_nxt (res_nxt),
    .exc_nxt (exc_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= MD_IDLE;
      count                <= '0;
      rd_q                 <= '0;
      div_q                <= 1'b0;
      multdiv_is_running   <= 1'b0;
      multdiv_result_ready <= 1'b0;
      multdiv_result       <= '0;
      multdiv_rd           <= '0;
      multdiv_exception    <= 1'b0;
      multdiv_rstatus      <= '0;
    end else begin
      multdiv_result_ready <= 1'b0;
      unique case (state)
        MD_IDLE, MD_DONE: begin
          if (load) begin
            state              <= MD_RUN;
            count              <= '0;
            rd_q               <= dec.rd;
            div_q              <= dec.is_div;
            multdiv_is_running <= 1'b1;
          end else begin
            state <= MD_IDLE;
          end
        end
        MD_RUN: begin
          count <= count + 1'b1;
          if (finish) begin
            state                <= MD_DONE;
            multdiv_is_running   <= 1'b0;
            multdiv_result_ready <= 1'b1;
            multdiv_result       <= res_nxt;
            multdiv_rd           <= rd_q;
            multdiv_exception    <= exc_nxt;
            multdiv_rstatus      <= !exc_nxt ? '0
                                  : div_q ? RSTATUS_DIV_EXC
                                  : RSTATUS_MUL_OVF;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed corners plus random
// ops against a plain-arithmetic reference model.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir    = '0;
  logic [31:0] opa   = '0;
  logic [31:0] opb   = '0;

  logic        running;
  logic        ready;
  logic [31:0] result;
  logic [4:0]  rd;
  logic        exc;
  logic [31:0] rstatus;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          lat;
    int          run;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] rs;
  } obs_t;

  always #5 clock = ~clock;

  multdiv_ctrl dut (
    .clock                (clock),
    .reset                (reset),
    .dx_ir_in             (ir),
    .dx_operand_a         (opa),
    .dx_operand_b         (opb),
    .multdiv_is_running   (running),
    .multdiv_result_ready (ready),
    .multdiv_result       (result),
    .multdiv_rd           (rd),
    .multdiv_exception    (exc),
    .multdiv_rstatus      (rstatus)
  );

  function automatic logic [31:0] mk_ir(input bit d,
                                        input logic [4:0] r);
    logic [14:0] junk;
    junk = 15'($urandom);
    return {5'b00000, r, junk, (d ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  task automatic model(input bit d, input logic [31:0] x, y,
                       output logic [31:0] r, output bit e,
                       output logic [31:0] rs, output int lat);
    int     sx;
    int     sy;
    longint p;
    bit     early;
    sx = x;
    sy = y;
    early = (x == 0) || (y == 0);
    if (!d) begin
      p = longint'(sx) * longint'(sy);
      r = p[31:0];
      e = p != longint'(int'(p[31:0]));
    end else if (y == 0) begin
      r = 0;
      e = 1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1;
      early = 1;
    end else begin
      r = sx / sy;
      e = 0;
    end
    rs = !e ? 32'd0 : (d ? 32'd5 : 32'd4);
`ifdef MULTDIV_EARLY_DONE_EN
    lat = early ? 2 : 33;
`else
    lat = early ? 33 : 33;
`endif
  endtask

  // Presents one op in DX for a single edge, then waits for ready.
  // lat counts edges from the latch edge to the edge raising ready.
  task automatic do_op(input bit d, input logic [4:0] r,
                       input logic [31:0] x, y, output obs_t o);
    ir  = mk_ir(d, r);
    opa = x;
    opb = y;
    @(posedge clock); #1;
    ir  = '0;
    opa = $urandom;
    opb = $urandom;
    o.run = int'(running);
    o.lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (running) o.run++;
      if (ready) begin
        o.lat = i + 1;
        break;
      end
    end
    o.res = result;
    o.rd  = rd;
    o.exc = exc;
    o.rs  = rstatus;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({running, ready, result, rd, exc, rstatus} !== '0) begin
      n_bad++;
      $display("FAIL reset: got run=%b rdy=%b res=%h rd=%0d exc=%b rs=%h want all 0",
               running, ready, result, rd, exc, rstatus);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_nonstart();
    logic [31:0] v;
    v = 32'h0000_0000;
    ir = v;
    @(posedge clock); #1;
    v = {5'b00001, 5'd3, 15'd0, 5'b00110, 2'b00};
    ir = v;
    @(posedge clock); #1;
    ir = '0;
    @(posedge clock); #1;
    n_cmp++;
    if (running !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL nonstart: got run=%b rdy=%b want 0 0",
               running, ready);
    end
  endtask

  task automatic test_directed();
    bit          td [5] = '{0, 0, 1, 1, 1};
    logic [31:0] ta [5] = '{32'h7, 32'h0001_0000, 32'hFFFF_FFEC,
                            32'h8000_0000, 32'h9};
    logic [31:0] tb [5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'h3,
                            32'hFFFF_FFFF, 32'h0};
    logic [31:0] wr [5] = '{32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFA,
                            32'h8000_0000, 32'h0};
    bit          we [5] = '{0, 1, 0, 1, 1};
    logic [31:0] ws [5] = '{32'd0, 32'd4, 32'd0, 32'd5, 32'd5};
    int          wl [5];
    obs_t        o;
    wl = '{33, 33, 33, 33, 33};
`ifdef MULTDIV_EARLY_DONE_EN
    wl[3] = 2;
    wl[4] = 2;
`endif
    for (int i = 0; i < 5; i++) begin
      do_op(td[i], 5'(i + 1), ta[i], tb[i], o);
      n_cmp += 6;
      if (o.lat !== wl[i]) begin
        n_bad++;
        $display("FAIL dir%0d latency: got %0d want %0d", i, o.lat, wl[i]);
      end
      if (o.run !== wl[i] - 1) begin
        n_bad++;
        $display("FAIL dir%0d running: got %0d want %0d",
                 i, o.run, wl[i] - 1);
      end
      if (o.res !== wr[i]) begin
        n_bad++;
        $display("FAIL dir%0d result: got %h want %h", i, o.res, wr[i]);
      end
      if (o.exc !== we[i]) begin
        n_bad++;
        $display("FAIL dir%0d exception: got %b want %b", i, o.exc, we[i]);
      end
      if (o.rs !== ws[i]) begin
        n_bad++;
        $display("FAIL dir%0d rstatus: got %h want %h", i, o.rs, ws[i]);
      end
      if (o.rd !== 5'(i + 1)) begin
        n_bad++;
        $display("FAIL dir%0d rd: got %0d want %0d", i, o.rd, i + 1);
      end
      @(posedge clock); #1;
      n_cmp++;
      if (ready !== 1'b0 || result !== wr[i]) begin
        n_bad++;
        $display("FAIL dir%0d hold: got rdy=%b res=%h want 0 %h",
                 i, ready, result, wr[i]);
      end
    end
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    obs_t        o;
    bit          d;
    logic [4:0]  r;
    logic [31:0] x, y, wr, ws;
    bit          we;
    int          wl;
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom);
      r = 5'($urandom);
      x = pick();
      y = pick();
      model(d, x, y, wr, we, ws, wl);
      do_op(d, r, x, y, o);
      n_cmp += 5;
      if (o.lat !== wl) begin
        n_bad++;
        $display("FAIL rnd%0d latency: got %0d want %0d", i, o.lat, wl);
      end
      if (o.res !== wr) begin
        n_bad++;
        $display("FAIL rnd%0d result %s %h,%h: got %h want %h",
                 i, d ? "div" : "mul", x, y, o.res, wr);
      end
      if (o.exc !== we) begin
        n_bad++;
        $display("FAIL rnd%0d exception: got %b want %b", i, o.exc, we);
      end
      if (o.rs !== ws) begin
        n_bad++;
        $display("FAIL rnd%0d rstatus: got %h want %h", i, o.rs, ws);
      end
      if (o.rd !== r) begin
        n_bad++;
        $display("FAIL rnd%0d rd: got %0d want %0d", i, o.rd, r);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    do_op(1'b0, 5'd5, 32'd1234, 32'hFFFF_FF00, o1);
    do_op(1'b1, 5'd6, 32'd1000, 32'd7, o2);
    n_cmp += 5;
    if (o1.rd !== 5'd5 || o2.rd !== 5'd6) begin
      n_bad++;
      $display("FAIL b2b rd: got %0d,%0d want 5,6", o1.rd, o2.rd);
    end
    if (o2.lat !== 33) begin
      n_bad++;
      $display("FAIL b2b spacing: got %0d want 33", o2.lat);
    end
    if (o1.res !== 32'hFFFB_2E00) begin
      n_bad++;
      $display("FAIL b2b result1: got %h want fffb2e00", o1.res);
    end
    if (o2.res !== 32'd142) begin
      n_bad++;
      $display("FAIL b2b result2: got %h want 0000008e", o2.res);
    end
    if (o2.exc !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b exception: got %b want 0", o2.exc);
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t o;
    bit   seen;
    ir  = mk_ir(1'b0, 5'd9);
    opa = 32'd300;
    opb = 32'd5;
    @(posedge clock); #1;
    ir = '0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if ({running, ready, result, rd, exc, rstatus} !== '0) begin
      n_bad++;
      $display("FAIL midreset: got run=%b rdy=%b res=%h rd=%0d exc=%b rs=%h want all 0",
               running, ready, result, rd, exc, rstatus);
    end
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (ready || running) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL midreset ghost: got activity=1 want 0");
    end
    do_op(1'b0, 5'd12, 32'hFFFF_FFF9, 32'd6, o);
    n_cmp += 3;
    if (o.lat !== 33) begin
      n_bad++;
      $display("FAIL postreset latency: got %0d want 33", o.lat);
    end
    if (o.res !== 32'hFFFF_FFD6) begin
      n_bad++;
      $display("FAIL postreset result: got %h want ffffffd6", o.res);
    end
    if (o.rd !== 5'd12) begin
      n_bad++;
      $display("FAIL postreset rd: got %0d want 12", o.rd);
    end
  endtask

  initial begin
    test_reset();
    test_nonstart();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
